// File: rtl/exec_step_controller_pkg.sv
// Shared state encodings and widths for the execution step controller.
package exec_step_controller_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  localparam int CYCLE_W = 32;
  localparam int DB_W    = 16;

endpackage

// File: rtl/exec_step_controller_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-sample counter and a
// registered one-cycle pulse on each accepted 0->1 level change.
module exec_step_controller_btn_debounce
  import exec_step_controller_pkg::*;
#(
  parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            level_dly_q, level_dly_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    // Any sample that agrees with the level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    level_dly_d = level_q;
    pulse_d     = level_q & ~level_dly_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/exec_step_controller.sv
// RUN / HALT / single-STEP clock-enable sequencer for the DataPath.
// Optional PC breakpoint is built when macro BREAKPOINT_EN is defined.
module exec_step_controller
  import exec_step_controller_pkg::*;
#(
  parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic            RESET_RUN       = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_halt,
  input  logic               btn_step,
  input  logic [31:0]        pc_in,
`ifdef BREAKPOINT_EN
  input  logic [31:0]        bp_addr,
  input  logic               bp_valid,
`endif
  output logic               cpu_en,
  output logic [1:0]         state,
  output logic               bp_hit,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam state_e RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

  logic               p_run, p_halt, p_step;
  logic               bp_now;
  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] count_q, count_d;

  exec_step_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clock(clock), .reset(reset), .btn_raw(btn_run), .pulse(p_run)
  );
  exec_step_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
    .clock(clock), .reset(reset), .btn_raw(btn_halt), .pulse(p_halt)
  );
  exec_step_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clock(clock), .reset(reset), .btn_raw(btn_step), .pulse(p_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (p_halt)      state_d = ST_HALT;
        else if (p_run)  state_d = ST_RUN;
        else if (p_step) state_d = ST_STEP;
      end
      ST_RUN:  if (p_halt || bp_now) state_d = ST_HALT;
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    cpu_en  = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~bp_now);
    count_d = count_q + {{(CYCLE_W-1){1'b0}}, cpu_en};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef BREAKPOINT_EN
  logic skip_q, skip_d;
  logic bp_hit_q, bp_hit_d;

  // skip masks the compare for the first RUN cycle so a resume at bp_addr executes it.
  assign bp_now = bp_valid & (pc_in == bp_addr) & ~skip_q & (state_q == ST_RUN);

  always_comb begin
    skip_d   = skip_q;
    bp_hit_d = bp_hit_q;
    if (state_d == ST_RUN && state_q != ST_RUN) skip_d = 1'b1;
    else if (state_q == ST_RUN)                 skip_d = 1'b0;
    if (bp_now)                                        bp_hit_d = 1'b1;
    else if (state_q == ST_HALT && state_d != ST_HALT) bp_hit_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      skip_q   <= RESET_RUN;
      bp_hit_q <= 1'b0;
    end else begin
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc_in;
  assign bp_now    = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign state       = state_q;
  assign cycle_count = count_q;

endmodule
